// File: rtl/hamming74_decoder.sv
// Hamming(7,4) decoder: syndrome in stage 1, optional single-bit correction in stage 2,
// valid/ready on both sides and a saturating count of delivered words with a nonzero syndrome.
module hamming74_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       cw_in,
    input  logic             correct_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             err_det,
    output logic [2:0]       err_pos,
    output logic             corrected,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       advance;
    logic [2:0] syn_in;
    logic       v1;
    logic [3:0] data1;
    logic       ce1;
    logic [2:0] syn1;
    logic       fix_en;
    logic [3:0] data_fix;
    logic       deliver_err;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign syn_in[0] = cw_in[0] ^ cw_in[2] ^ cw_in[4] ^ cw_in[6];
    assign syn_in[1] = cw_in[1] ^ cw_in[2] ^ cw_in[5] ^ cw_in[6];
    assign syn_in[2] = cw_in[3] ^ cw_in[4] ^ cw_in[5] ^ cw_in[6];

    // Only the data bits are carried forward; a flipped parity bit never reaches data_out,
    // so the syndrome alone is enough to describe it.
    always_comb begin
        fix_en   = ce1 && (syn1 != 3'd0);
        data_fix = data1;
        if (fix_en) begin
            case (syn1)
                3'd3:    data_fix[0] = ~data1[0];
                3'd5:    data_fix[1] = ~data1[1];
                3'd6:    data_fix[2] = ~data1[2];
                3'd7:    data_fix[3] = ~data1[3];
                default: data_fix    = data1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            data1     <= 4'd0;
            ce1       <= 1'b0;
            syn1      <= 3'd0;
            out_valid <= 1'b0;
            data_out  <= 4'd0;
            err_det   <= 1'b0;
            err_pos   <= 3'd0;
            corrected <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            data1     <= {cw_in[6], cw_in[5], cw_in[4], cw_in[2]};
            ce1       <= correct_en;
            syn1      <= syn_in;
            out_valid <= v1;
            data_out  <= data_fix;
            err_det   <= (syn1 != 3'd0);
            err_pos   <= syn1;
            corrected <= fix_en;
        end
    end

    assign deliver_err = out_valid && out_ready && err_det;

    // Clear beats a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            err_cnt <= '0;
        end else if (deliver_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming74_decoder.sv
// Scoreboard bench for hamming74_decoder: a driver pushes reference-model results, a monitor
// pops them on each output handshake; a second instance with CNT_W=2 exercises saturation.
module tb_hamming74_decoder;

    logic       clk = 1'b0;
    logic       rst, in_valid, correct_en, out_ready, cnt_clr;
    logic [6:0] cw_in;
    logic       in_ready, out_valid, err_det, corrected;
    logic [3:0] data_out;
    logic [2:0] err_pos;
    logic [7:0] err_cnt;
    logic       in_ready2, out_valid2, err_det2, corrected2;
    logic [3:0] data_out2;
    logic [2:0] err_pos2;
    logic [1:0] err_cnt2;

    always #5 clk = ~clk;

    hamming74_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cw_in(cw_in),
        .correct_en(correct_en), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_det(err_det), .err_pos(err_pos), .corrected(corrected),
        .cnt_clr(cnt_clr), .err_cnt(err_cnt)
    );

    hamming74_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .cw_in(cw_in),
        .correct_en(correct_en), .out_valid(out_valid2), .out_ready(out_ready),
        .data_out(data_out2), .err_det(err_det2), .err_pos(err_pos2), .corrected(corrected2),
        .cnt_clr(cnt_clr), .err_cnt(err_cnt2)
    );

    typedef struct packed {
        logic [3:0] data;
        logic       det;
        logic [2:0] pos;
        logic       corr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Syndrome as the XOR of the 1-based positions of all set bits.
    function automatic logic [2:0] ref_syn(input logic [6:0] cw);
        logic [2:0] s = 3'd0;
        for (int i = 1; i <= 7; i++)
            if (cw[i-1]) s = s ^ 3'(i);
        return s;
    endfunction

    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [6:0] cw = 7'd0;
        logic [2:0] s;
        cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
        s = ref_syn(cw);
        cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
        return cw;
    endfunction

    function automatic exp_t ref_dec(input logic [6:0] cw, input logic ce);
        exp_t       r;
        logic [6:0] f = cw;
        logic [2:0] s = ref_syn(cw);
        int         p;
        if (s != 3'd0 && ce) begin
            p = int'(s) - 1;
            f[p] = ~f[p];
        end
        r.data = {f[6], f[5], f[4], f[2]};
        r.det  = (s != 3'd0);
        r.pos  = s;
        r.corr = (s != 3'd0) && ce;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cnt_clr = (ready_mode == 1) && ($urandom_range(0, 19) == 0);
    endtask

    task automatic send(input logic [6:0] cw, input logic ce);
        bit acc = 1'b0;
        in_valid   = 1'b1;
        cw_in      = cw;
        correct_en = ce;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(ref_dec(cw, ce));
                acc = 1'b1;
            end
            step();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted cw=%b", cw);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 100 && (sb.size() != 0 || out_valid); n++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [6:0] rand_word();
        logic [6:0] cw = ref_enc(4'($urandom_range(0, 15)));
        int         k  = $urandom_range(0, 9);
        int         a  = $urandom_range(0, 6);
        int         b  = (a + $urandom_range(1, 6)) % 7;
        if (k >= 4) cw[a] = ~cw[a];
        if (k == 9) cw[b] = ~cw[b];
        return cw;
    endfunction

    // out_ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = ($urandom_range(0, 9) < 7);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshake checks, stall stability and counter model.
    initial begin
        exp_t e, prev, cur, cur2;
        int   c8, c2;
        bit   stall_prev, inc;
        c8 = 0; c2 = 0; stall_prev = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                c8 = 0; c2 = 0; stall_prev = 1'b0;
            end else begin
                cur  = {data_out, err_det, err_pos, corrected};
                cur2 = {data_out2, err_det2, err_pos2, corrected2};
                chk("err_cnt", 32'(err_cnt), 32'(c8));
                chk("err_cnt_w2", 32'(err_cnt2), 32'(c2));
                chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                chk("in_ready_w2", 32'(in_ready2), 32'(!(out_valid2 && !out_ready)));
                if (stall_prev) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_payload", 32'(cur), 32'(prev));
                end
                inc = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%h required=none at %0t", cur, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("payload", 32'(cur), 32'(e));
                        chk("payload_w2", 32'(cur2), 32'(e));
                        chk("out_valid_w2", 32'(out_valid2), 32'd1);
                        inc = e.det;
                    end
                end
                if (cnt_clr) begin
                    c8 = 0; c2 = 0;
                end else if (inc) begin
                    if (c8 < 255) c8++;
                    if (c2 < 3) c2++;
                end
                stall_prev = out_valid && !out_ready;
                prev = cur;
            end
        end
    end

    initial begin
        logic [6:0] cw;
        rst = 1'b1; in_valid = 1'b0; cw_in = 7'd0; correct_en = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_payload", 32'({data_out, err_det, err_pos, corrected}), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Directed words: clean, corrected, detect-only.
        send(7'b1010101, 1'b1);
        send(7'b1000101, 1'b1);
        send(7'b1000101, 1'b0);
        send(7'b0000001, 1'b1);
        drain();

        // Every single-bit error position for two data values.
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 7; p++) begin
                cw = ref_enc((d == 0) ? 4'b1011 : 4'b0000);
                cw[p] = ~cw[p];
                send(cw, 1'b1);
            end
        drain();

        // Backpressure: five back-to-back words with out_ready low for three cycles.
        fork
            begin
                for (int i = 0; i < 5; i++) send(rand_word(), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                ready_mode = 2;
                repeat (3) @(posedge clk);
                ready_mode = 0;
            end
        join
        drain();

        // Counter saturation after a clear, then clear on the same edge as an error delivery.
        cnt_clr = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            cw = ref_enc(4'(i + 3));
            cw[i] = ~cw[i];
            send(cw, 1'b1);
        end
        in_valid = 1'b0;
        drain();
        cw = ref_enc(4'b0110);
        cw[6] = ~cw[6];
        send(cw, 1'b0);
        in_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid && err_det) begin
                cnt_clr = 1'b1;
                break;
            end
        end
        step();
        drain();

        // Random traffic with random backpressure, idle gaps and clears.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rand_word(), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        ready_mode = 0;
        drain();

        // Reset with two words in flight: nothing from before the reset may emerge.
        ready_mode = 2;
        step();
        step();
        send(rand_word(), 1'b1);
        send(rand_word(), 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_err_cnt_w2", 32'(err_cnt2), 32'd0);
        ready_mode = 0;
        repeat (8) step();
        send(7'b1010101, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
